// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES types and helpers for the key-schedule and cipher blocks.
//   word_t     : one 32-bit AES word
//   key_t      : one 128-bit round key {W0,W1,W2,W3}, W0 in bits [127:96]
//   state_t    : inverse key-scheduler FSM states
//   rcon()     : round constant word for round 1..10 (zero elsewhere)
//   rot_word() : cyclic byte rotation (a,b,c,d) -> (b,c,d,a)
// -----------------------------------------------------------------------------
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] key_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_SUB  = 2'd2,
    ST_EXP  = 2'd3
  } state_t;

  // Round constant sits in the top byte; the low 24 bits are always zero.
  function automatic word_t rcon(input logic [3:0] round);
    logic [7:0] rc;
    case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h000000};
  endfunction

  // Byte a is the most significant byte of the word.
  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// -----------------------------------------------------------------------------
// aes_sub_word
// Purely combinational SubWord: four forward AES S-box lookups, one per byte.
// Shared by the forward expander, the cipher and the inverse key scheduler.
// Ports:
//   i_word : input word
//   o_word : S-box substituted word (byte lanes preserved)
// -----------------------------------------------------------------------------
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  // Forward S-box, entry 0x00 in the top byte; entry b lives at bit
  // (255-b)*8, which for an 8-bit b is simply {~b, 3'b000}.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return SBOX[idx +: 8];
  endfunction

  assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                   sbox(i_word[15:8]),  sbox(i_word[7:0])};

endmodule

// File: rtl/aes_inv_key_scheduler.sv
// -----------------------------------------------------------------------------
// aes_inv_key_scheduler
// Reverse AES-128 key schedule for on-the-fly decryption. Loads the round-10
// key and emits K10, K9, ... K0, one key per valid/ready handshake.
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   start     : one-cycle request, honoured only in IDLE
//   last_key  : round-10 key {W0,W1,W2,W3}, W0 = bits [127:96]
//   key_out   : current round key
//   key_round : round index of key_out (10..0)
//   key_valid : key_out / key_round valid
//   key_ready : consumer accepts on key_valid & key_ready
//   busy      : high from the cycle after start until done
//   done      : one-cycle pulse after K0 is accepted
//
// Build option INV_KS_FAST_EN: when defined the SUB state is skipped and
// SubWord is captured on the EMIT handshake (2 cycles per key instead of 3).
// -----------------------------------------------------------------------------
module aes_inv_key_scheduler
  import aes_pkg::*;
#(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [KW-1:0] last_key,
  output logic [KW-1:0] key_out,
  output logic [3:0]    key_round,
  output logic          key_valid,
  input  logic          key_ready,
  output logic          busy,
  output logic          done
);

  state_t     r_state;
  state_t     w_state_next;
  key_t       r_key;
  logic [3:0] r_round;
  word_t      r_sub;
  logic       r_key_valid;
  logic       r_busy;
  logic       r_done;

  word_t      w_w0;
  word_t      w_w1;
  word_t      w_w2;
  word_t      w_w3;
  word_t      w_t3;
  word_t      w_rot;
  word_t      w_sub;
  logic       w_start_ok;
  logic       w_hs;
  logic       w_last_hs;

  assign w_w0 = r_key[127:96];
  assign w_w1 = r_key[95:64];
  assign w_w2 = r_key[63:32];
  assign w_w3 = r_key[31:0];

  // W3 of the previous round key, the input to that round's g() function.
  assign w_t3  = w_w3 ^ w_w2;
  assign w_rot = rot_word(w_t3);

  aes_sub_word u_sub_word (
    .i_word (w_rot),
    .o_word (w_sub)
  );

  // A start arriving while done is still high belongs to the finished run.
  assign w_start_ok = (r_state == ST_IDLE) && start && !r_done;
  assign w_hs       = (r_state == ST_EMIT) && key_ready;
  assign w_last_hs  = w_hs && (r_round == 4'd0);

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_state_next = ST_EMIT;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (w_last_hs) begin
          w_state_next = ST_IDLE;
        end else if (w_hs) begin
`ifdef INV_KS_FAST_EN
          w_state_next = ST_EXP;
`else
          w_state_next = ST_SUB;
`endif
        end else begin
          w_state_next = ST_EMIT;
        end
      end
      ST_SUB:  w_state_next = ST_EXP;
      ST_EXP:  w_state_next = ST_EMIT;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Key, round counter and SubWord holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key   <= '0;
      r_round <= 4'd0;
      r_sub   <= 32'h00000000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_key   <= last_key;
            r_round <= 4'(NR);
          end
        end
        ST_EMIT: begin
`ifdef INV_KS_FAST_EN
          if (w_hs && !w_last_hs) begin
            r_sub <= w_sub;
          end
`endif
        end
        ST_SUB: begin
          r_sub <= w_sub;
        end
        ST_EXP: begin
          // Undo one forward step: each word is recovered from its neighbour.
          r_key   <= {w_w0 ^ r_sub ^ rcon(r_round), w_w1 ^ w_w0,
                      w_w2 ^ w_w1, w_w3 ^ w_w2};
          r_round <= r_round - 4'd1;
        end
        default: begin
          r_round <= r_round;
        end
      endcase
    end
  end

  // Registered handshake/status outputs, derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_key_valid <= (w_state_next == ST_EMIT);
      r_busy      <= (w_state_next != ST_IDLE);
      r_done      <= w_last_hs;
    end
  end

  assign key_out   = r_key;
  assign key_round = r_round;
  assign key_valid = r_key_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_aes_inv_key_scheduler.sv
module tb_aes_inv_key_scheduler;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] last_key;
  logic [127:0] key_out;
  logic [3:0]   key_round;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         done;

  aes_inv_key_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .last_key  (last_key),
    .key_out   (key_out),
    .key_round (key_round),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // FIPS-197 A.1 round keys, indexed by round.
  logic [127:0] fips_k [0:10];
  logic [127:0] zero_k10;
  logic [127:0] zero_k1;

`ifdef INV_KS_FAST_EN
  localparam int EXP_SPAN = 21;
`else
  localparam int EXP_SPAN = 31;
`endif

  // Observations gathered by run_seq.
  logic [127:0] obs_key   [0:15];
  logic [3:0]   obs_round [0:15];
  int n_obs, first_valid_cyc, done_cyc, last_hs_cyc;
  int stab_err, busy_low, done_count;
  bit timed_out;

  // Drives one start and follows the key stream until done (or abort/budget).
  task automatic run_seq(input logic [127:0] lk, input bit rand_ready,
                         input int inject_round, input int abort_round,
                         input int budget);
    int cyc;
    bit injected;
    bit prev_stall;
    logic [127:0] pk;
    logic [3:0] pr;
    n_obs = 0; first_valid_cyc = -1; done_cyc = -1; last_hs_cyc = -1;
    stab_err = 0; busy_low = 0; done_count = 0; timed_out = 0;
    injected = 0; prev_stall = 0; pk = '0; pr = 4'd0;
    @(negedge clk);
    start = 1'b1;
    last_key = lk;
    key_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (cyc < budget) begin
      if (start) start = 1'b0;
      if (done) begin
        done_cyc = cyc;
        done_count++;
        break;
      end
      if (key_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (prev_stall && (key_out !== pk || key_round !== pr)) stab_err++;
        if (abort_round >= 0 && int'(key_round) == abort_round) break;
        if (!busy) busy_low++;
        if (inject_round >= 0 && !injected && int'(key_round) == inject_round) begin
          start = 1'b1;
          last_key = ~lk;
          injected = 1;
        end
        key_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (key_ready) begin
          if (n_obs < 16) begin
            obs_key[n_obs] = key_out;
            obs_round[n_obs] = key_round;
          end
          n_obs++;
          last_hs_cyc = cyc;
        end
        prev_stall = !key_ready;
        pk = key_out;
        pr = key_round;
      end else begin
        if (first_valid_cyc >= 0 && !busy) busy_low++;
        prev_stall = 0;
        key_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= budget) timed_out = 1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    tests_run++;
    if (key_out !== 128'h0 || key_round !== 4'd0 || key_valid !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got key=%h rnd=%0d v=%b b=%b d=%b want all zero",
               key_out, key_round, key_valid, busy, done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (key_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got v=%b b=%b want 0 0", key_valid, busy);
    end
  endtask

  task automatic test_fips;
    run_seq(fips_k[10], 1'b0, -1, -1, 200);
    tests_run++;
    if (timed_out !== 1'b0 || n_obs != 11) begin
      tests_failed++;
      $display("FAIL fips_count: got %0d keys timeout=%b want 11 keys", n_obs, timed_out);
    end
    for (int i = 0; i < 11 && i < n_obs; i++) begin
      tests_run++;
      if (obs_round[i] !== 4'(10 - i) || obs_key[i] !== fips_k[10 - i]) begin
        tests_failed++;
        $display("FAIL fips_key idx%0d: got r%0d %h want r%0d %h",
                 i, obs_round[i], obs_key[i], 10 - i, fips_k[10 - i]);
      end
    end
    tests_run++;
    if (done_cyc != last_hs_cyc + 1) begin
      tests_failed++;
      $display("FAIL fips_done_latency: got done at %0d want %0d", done_cyc, last_hs_cyc + 1);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || key_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL fips_after_done: got d=%b b=%b v=%b want 0 0 0", done, busy, key_valid);
    end
  endtask

  task automatic test_zero_key;
    run_seq(zero_k10, 1'b0, -1, -1, 200);
    tests_run++;
    if (timed_out !== 1'b0 || n_obs != 11) begin
      tests_failed++;
      $display("FAIL zero_count: got %0d keys timeout=%b want 11", n_obs, timed_out);
    end
    for (int i = 0; i < 11 && i < n_obs; i++) begin
      tests_run++;
      if (obs_round[i] !== 4'(10 - i)) begin
        tests_failed++;
        $display("FAIL zero_round idx%0d: got %0d want %0d", i, obs_round[i], 10 - i);
      end
    end
    tests_run++;
    if (obs_key[0] !== zero_k10 || obs_key[9] !== zero_k1 || obs_key[10] !== 128'h0) begin
      tests_failed++;
      $display("FAIL zero_keys: got k10=%h k1=%h k0=%h want %h %h 0",
               obs_key[0], obs_key[9], obs_key[10], zero_k10, zero_k1);
    end
  endtask

  task automatic test_start_on_done;
    // run_seq returns on the cycle done is high; start here must be ignored.
    run_seq(zero_k10, 1'b0, -1, -1, 200);
    start = 1'b1;
    last_key = fips_k[10];
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    tests_run++;
    if (done_count != 1 || key_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_on_done: got done_cnt=%0d v=%b b=%b want 1 0 0",
               done_count, key_valid, busy);
    end
  endtask

  task automatic test_backpressure;
    run_seq(fips_k[10], 1'b1, -1, -1, 600);
    tests_run++;
    if (timed_out !== 1'b0 || n_obs != 11) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d keys timeout=%b want 11", n_obs, timed_out);
    end
    for (int i = 0; i < 11 && i < n_obs; i++) begin
      tests_run++;
      if (obs_round[i] !== 4'(10 - i) || obs_key[i] !== fips_k[10 - i]) begin
        tests_failed++;
        $display("FAIL bp_key idx%0d: got r%0d %h want r%0d %h",
                 i, obs_round[i], obs_key[i], 10 - i, fips_k[10 - i]);
      end
    end
    tests_run++;
    if (stab_err != 0) begin
      tests_failed++;
      $display("FAIL bp_stable: got %0d changes under stall want 0", stab_err);
    end
  endtask

  task automatic test_start_while_busy;
    run_seq(fips_k[10], 1'b0, 5, -1, 200);
    tests_run++;
    if (timed_out !== 1'b0 || n_obs != 11 || done_count != 1) begin
      tests_failed++;
      $display("FAIL busy_count: got %0d keys done=%0d want 11 keys 1 done", n_obs, done_count);
    end
    for (int i = 0; i < 11 && i < n_obs; i++) begin
      tests_run++;
      if (obs_key[i] !== fips_k[10 - i]) begin
        tests_failed++;
        $display("FAIL busy_key idx%0d: got %h want %h", i, obs_key[i], fips_k[10 - i]);
      end
    end
    tests_run++;
    if (busy_low != 0) begin
      tests_failed++;
      $display("FAIL busy_level: got %0d low cycles want 0", busy_low);
    end
  endtask

  task automatic test_reset_mid;
    int bad_done;
    run_seq(fips_k[10], 1'b0, -1, 4, 200);
    tests_run++;
    if (n_obs != 6) begin
      tests_failed++;
      $display("FAIL mid_reach_r4: got %0d keys before abort want 6", n_obs);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (key_out !== 128'h0 || key_round !== 4'd0 || key_valid !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: got key=%h rnd=%0d v=%b b=%b d=%b want all zero",
               key_out, key_round, key_valid, busy, done);
    end
    bad_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done !== 1'b0) bad_done++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (done !== 1'b0) bad_done++;
    end
    tests_run++;
    if (bad_done != 0) begin
      tests_failed++;
      $display("FAIL mid_no_done: got %0d done cycles want 0", bad_done);
    end
    run_seq(zero_k10, 1'b0, -1, -1, 200);
    tests_run++;
    if (n_obs != 11 || obs_key[0] !== zero_k10 || obs_key[10] !== 128'h0 ||
        obs_round[10] !== 4'd0) begin
      tests_failed++;
      $display("FAIL mid_restart: got %0d keys k10=%h k0=%h want 11 %h 0",
               n_obs, obs_key[0], obs_key[10], zero_k10);
    end
  endtask

  task automatic test_timing;
    run_seq(fips_k[10], 1'b0, -1, -1, 200);
    tests_run++;
    if (first_valid_cyc != 0) begin
      tests_failed++;
      $display("FAIL start_latency: got %0d want 0", first_valid_cyc);
    end
    tests_run++;
    if (done_cyc - first_valid_cyc != EXP_SPAN) begin
      tests_failed++;
      $display("FAIL timing_span: got %0d cycles want %0d", done_cyc - first_valid_cyc, EXP_SPAN);
    end
  endtask

  initial begin
    fips_k[0]  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    fips_k[1]  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    fips_k[2]  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
    fips_k[3]  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
    fips_k[4]  = 128'hef44a541_a8525b7f_b671253b_db0bad00;
    fips_k[5]  = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
    fips_k[6]  = 128'h6d88a37a_110b3efd_dbf98641_ca0093fd;
    fips_k[7]  = 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f;
    fips_k[8]  = 128'head27321_b58dbad2_312bf560_7f8d292f;
    fips_k[9]  = 128'hac7766f3_19fadc21_28d12941_575c006e;
    fips_k[10] = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    zero_k10   = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;
    zero_k1    = 128'h62636363_62636363_62636363_62636363;

    rst_n = 1'b0;
    start = 1'b0;
    key_ready = 1'b0;
    last_key = '0;
    @(negedge clk);

    test_reset();
    test_fips();
    test_zero_key();
    test_start_on_done();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid();
    test_timing();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_inv_key_scheduler.md
Name: aes_inv_key_scheduler

Overview:
Reverse AES-128 key schedule for on-the-fly decryption. Loads the round-10 key and emits round keys 10, 9, … 0 in that order, one per valid/ready handshake. Each step undoes one forward expansion step. Sits beside the decrypt datapath, which consumes K10 first and K0 last.

Parameters:
NR, 10, number of rounds; fixed for AES-128, only 10 supported.
KW, 128, key width in bits.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
last_key  in  128  round-10 key {W0,W1,W2,W3}; W0 = bits [127:96]
key_out  out  128  current round key
key_round  out  4  round index of key_out (10..0)
key_valid  out  1  key_out/key_round valid
key_ready  in  1  consumer accepts key when key_valid & key_ready
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse after K0 is accepted

Behaviour:
- Reset (async assert, sync release): state=IDLE; key_out=0, key_round=0, key_valid=0, busy=0, done=0, sub_reg=0.
- FSM states: IDLE, EMIT, SUB, EXP.
- IDLE: on start, key_reg<=last_key, round<=10, busy<=1, go to EMIT. key_valid is high the next cycle (latency 1).
- EMIT: key_valid=1. key_out and key_round hold stable while key_ready=0. On handshake: if round==0, go to IDLE, pulse done, drop busy. Otherwise go to SUB.
- SUB: t3 = W3^W2 (previous-round W3). sub_reg <= SubWord(RotWord(t3)). RotWord(a,b,c,d) = (b,c,d,a).
- EXP: previous key = {W0^sub_reg^Rcon[round], W1^W0, W2^W1, W3^W2}; round<=round-1; go to EMIT.
- Rcon[r] is the top byte, low 24 bits zero. r=1..10 → 01,02,04,08,10,20,40,80,1B,36. Other r → 0; unreachable.
- Throughput: 3 cycles per key with key_ready tied high. 11 keys = 31 cycles from the first key_valid to done.
- start while busy: ignored, no restart. start in the same cycle as done: ignored; IDLE is entered the following cycle.
- key_valid never drops without a handshake. key_out only changes in EXP.
- rst_n low mid-sequence returns to IDLE immediately. No done pulse. Outputs take their reset values.
- All XORs are 32-bit word-wise. There is no carry arithmetic.

Optional Feature:
INV_KS_FAST_EN
- Defined: SUB state removed. SubWord is computed combinationally from the EMIT-state key and registered on the EMIT handshake. Costs 2 cycles per key; 11 keys = 21 cycles from the first key_valid to done. Output values and ordering are unchanged.
- Undefined: 3-state step as above.

Decomposition:
- Package aes_pkg:
  - word typedef (32-bit).
  - key typedef (128-bit).
  - FSM state enum.
  - rcon(round) function.
  - RotWord function.
- Sub-module aes_sub_word: combinational, four AES forward S-box byte lookups on a 32-bit word. It is reused by the forward expander and the cipher.

Test Plan:
1. FIPS-197 key 2b7e1516_28aed2a6_abf71588_09cf4f3c:
   - Stimulus: start with last_key = d014f9a8_c9ee2589_e13f0cc8_b6630ca6, key_ready=1.
   - Required: first key round 10 = last_key; round 9 = ac7766f3_19fadc21_28d12941_575c006e; round 0 = the cipher key; done one cycle after the K0 handshake.
2. All-zero cipher key:
   - Stimulus: last_key = b4ef5bcb_3e92e211_23e951cf_6f8f188e.
   - Required: key_round counts 10..0; final key_out = 0.
3. Backpressure:
   - Stimulus: key_ready random with 50% duty on vector 1.
   - Required: same 11 keys in order; key_out/key_round stable while key_valid & !key_ready.
4. Start while busy:
   - Stimulus: pulse start with a different last_key at round 5.
   - Required: sequence unaffected; busy stays 1.
5. Reset mid-operation:
   - Stimulus: drop rst_n at round 4, release, then start vector 2.
   - Required: all outputs zero during reset; no done pulse; clean vector 2 sequence after release.
6. Timing per build:
   - Stimulus: vector 1 with key_ready=1, with and without INV_KS_FAST_EN.
   - Required: 31 vs 21 cycles from the first key_valid to done; identical key stream.
